// File: rtl/core_dispatch.sv
// core_dispatch: receives a header plus LEN words into an input buffer,
// starts the selected compute engine, waits for it, then streams LEN words
// out of the output buffer one per tx_done edge.
// Optional build macro CORE_DISPATCH_TIMEOUT_EN adds a COMPUTE watchdog.
module core_dispatch #(
  parameter int DATA_W    = 16,
  parameter int BUF_DEPTH = 128,
  parameter int NUM_ENG   = 2,
  parameter int TIMEOUT   = 4096
) (
  input  logic                         clk,
  input  logic                         rstb,
  input  logic [DATA_W-1:0]            data_in,
  input  logic                         data_in_valid,
  input  logic                         tx_done,
  output logic [DATA_W-1:0]            data_out,
  output logic                         data_out_valid,
  output logic                         core_busy,
  output logic                         err,
  output logic [NUM_ENG-1:0]           eng_start,
  input  logic [NUM_ENG-1:0]           eng_done,
  input  logic [$clog2(BUF_DEPTH)-1:0] ibuf_raddr,
  output logic [DATA_W-1:0]            ibuf_rdata,
  input  logic                         obuf_we,
  input  logic [$clog2(BUF_DEPTH)-1:0] obuf_waddr,
  input  logic [DATA_W-1:0]            obuf_wdata
);

  localparam int AW = $clog2(BUF_DEPTH);
  // one extra bit so a count of BUF_DEPTH is representable
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_START,
    S_COMPUTE,
    S_TX
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       len_q;
  logic [3:0]          sel_q;
  logic [DATA_W-1:0]   data_out_q;
  logic                dov_q;
  logic                busy_q;
  logic                err_q;
  logic [NUM_ENG-1:0]  eng_start_q;
  logic                din_q;
  logic                txd_q;

  logic [DATA_W-1:0]   ibuf [BUF_DEPTH];
  logic [DATA_W-1:0]   obuf [BUF_DEPTH];

  logic                din_edge;
  logic                tx_edge;
  logic [3:0]          hdr_sel;
  logic [31:0]         hdr_len;
  logic                hdr_bad;
  logic [NUM_ENG-1:0]  sel_oh;
  logic                done_sel;
  logic                unused_ok;

`ifdef CORE_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]       tmo_q;
`endif

  assign din_edge = data_in_valid & ~din_q;
  assign tx_edge  = tx_done & ~txd_q;

  // header decode; compared at 32 bits so LEN=BUF_DEPTH never truncates
  assign hdr_sel = data_in[3:0];
  assign hdr_len = 32'(data_in[DATA_W-1:8]);
  assign hdr_bad = (32'(hdr_sel) >= 32'(NUM_ENG)) || (hdr_len == 32'd0) ||
                   (hdr_len > 32'(BUF_DEPTH));

`ifdef CORE_DISPATCH_TIMEOUT_EN
  assign unused_ok = ^data_in[7:4];
`else
  assign unused_ok = ^{data_in[7:4], 32'(TIMEOUT)};
`endif

  // one-hot of the latched engine select, used for start and done masking
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NUM_ENG; i++) sel_oh[i] = (sel_q == 4'(i));
  end

  assign done_sel = |(eng_done & sel_oh);

  assign data_out       = data_out_q;
  assign data_out_valid = dov_q;
  assign core_busy      = busy_q;
  assign err            = err_q;
  assign eng_start      = eng_start_q;
  assign ibuf_rdata     = ibuf[ibuf_raddr];

  // previous-cycle copies of the level inputs for rising-edge detection
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      din_q <= 1'b0;
      txd_q <= 1'b0;
    end else begin
      din_q <= data_in_valid;
      txd_q <= tx_done;
    end
  end

  // input buffer fill while receiving payload words
  always_ff @(posedge clk) begin
    if (state_q == S_RECV && din_edge) ibuf[cnt_q[AW-1:0]] <= data_in;
  end

  // engine writes to the output buffer are accepted in any state
  always_ff @(posedge clk) begin
    if (obuf_we) obuf[obuf_waddr] <= obuf_wdata;
  end

  // command sequencer with registered outputs
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      sel_q       <= '0;
      data_out_q  <= '0;
      dov_q       <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      eng_start_q <= '0;
`ifdef CORE_DISPATCH_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      dov_q       <= 1'b0;
      eng_start_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (din_edge) begin
            if (hdr_bad) begin
              err_q <= 1'b1;
            end else begin
              err_q   <= 1'b0;
              sel_q   <= hdr_sel;
              len_q   <= hdr_len[CW-1:0];
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= S_RECV;
            end
          end
        end
        S_RECV: begin
          if (din_edge) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == len_q - CW'(1)) begin
              eng_start_q <= sel_oh;
              state_q     <= S_START;
            end
          end
        end
        S_START: begin
          state_q <= S_COMPUTE;
`ifdef CORE_DISPATCH_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end
        S_COMPUTE: begin
          if (done_sel) begin
            data_out_q <= obuf[0];
            dov_q      <= 1'b1;
            cnt_q      <= CW'(1);
            state_q    <= S_TX;
          end
`ifdef CORE_DISPATCH_TIMEOUT_EN
          else if (tmo_q == TW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
`endif
        end
        S_TX: begin
          if (tx_edge) begin
            if (cnt_q < len_q) begin
              data_out_q <= obuf[cnt_q[AW-1:0]];
              dov_q      <= 1'b1;
              cnt_q      <= cnt_q + CW'(1);
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/core_dispatch.md
CORE_DISPATCH -- requirements
Module: core_dispatch

Interface
REQ-001 SHALL have parameter DATA_W, default 16: word width of every data port.
REQ-002 SHALL have parameter BUF_DEPTH, default 128: input-buffer and output-buffer depth in words; power of two, at most 2^(DATA_W-8).
REQ-003 SHALL have parameter NUM_ENG, default 2, range 1..16: number of attached compute engines.
REQ-004 SHALL have parameter TIMEOUT, default 4096: compute watchdog limit in clk cycles.
REQ-005 Ports, in this order:
- clk  in  1  single clock; all logic on posedge.
- rstb  in  1  asynchronous, active-low reset.
- data_in  in  DATA_W  receive word.
- data_in_valid  in  1  level; each rising edge delivers one word.
- tx_done  in  1  level; each rising edge means the current output word was consumed.
- data_out  out  DATA_W  transmit word.
- data_out_valid  out  1  one-cycle pulse per new data_out.
- core_busy  out  1  high in every state except IDLE.
- err  out  1  sticky error flag.
- eng_start  out  NUM_ENG  one-hot, one-cycle start pulse.
- eng_done  in  NUM_ENG  engine completion, level.
- ibuf_raddr  in  log2(BUF_DEPTH)  engine read address into the input buffer.
- ibuf_rdata  out  DATA_W  combinational read data for ibuf_raddr.
- obuf_we  in  1  engine write enable into the output buffer.
- obuf_waddr  in  log2(BUF_DEPTH)  engine write address.
- obuf_wdata  in  DATA_W  engine write data.

Function
REQ-006 SHALL detect edges by registering data_in_valid and tx_done each cycle; an edge is current=1 and previous=0.
REQ-007 States SHALL be IDLE, RECEIVE, START, COMPUTE, TRANSMIT.
REQ-008 IDLE: a data_in_valid edge is a header. SEL=data_in[3:0]; LEN=data_in[DATA_W-1:8]; the header edge clears err.
REQ-009 If SEL>=NUM_ENG, or LEN=0, or LEN>BUF_DEPTH, the block SHALL set err and remain in IDLE; otherwise it latches SEL and LEN, clears the word counter and moves to RECEIVE.
REQ-010 RECEIVE: each edge writes data_in to ibuf[counter] and increments the counter; the edge that writes word LEN-1 moves to START.
REQ-011 START: eng_start[SEL] is high for exactly this one cycle; next state is COMPUTE.
REQ-012 COMPUTE: obuf_we writes obuf_wdata to obuf[obuf_waddr]; writes are accepted in every state.
REQ-013 COMPUTE exit: the first cycle with eng_done[SEL]=1 SHALL load data_out=obuf[0], pulse data_out_valid, set counter=1 and move to TRANSMIT; eng_done of unselected engines is ignored.
REQ-014 TRANSMIT: on each tx_done edge, if counter<LEN, load obuf[counter], pulse data_out_valid and increment; if counter=LEN, return to IDLE with no pulse.
REQ-015 data_out SHALL hold its last value between pulses.
REQ-016 Exactly LEN output words SHALL be emitted per command; the LEN=1 case returns to IDLE on the first tx_done edge.
REQ-017 data_in_valid edges outside IDLE and RECEIVE SHALL be ignored; tx_done edges outside TRANSMIT SHALL be ignored.
REQ-018 A data_in_valid edge and a tx_done edge arriving in the same cycle SHALL each be handled per the current state only.
REQ-019 Counters SHALL be log2(BUF_DEPTH)+1 bits wide, so no wrap occurs at LEN=BUF_DEPTH.

Reset
REQ-020 On rstb low the block SHALL asynchronously enter IDLE and clear: data_out=0, data_out_valid=0, core_busy=0, err=0, eng_start=0, counters, and the edge-detect registers.
REQ-021 A reset mid-command SHALL discard the command; buffer contents need not be reset.

Configuration
REQ-022 With CORE_DISPATCH_TIMEOUT_EN defined, COMPUTE counts cycles; when the count reaches TIMEOUT without eng_done[SEL], the block SHALL set err, emit no output and return to IDLE.
REQ-023 Without CORE_DISPATCH_TIMEOUT_EN, COMPUTE SHALL wait indefinitely and no watchdog logic is present.

Verification
REQ-024 Header SEL=1, LEN=4, words 0x11..0x14; engine writes obuf 0xA0..0xA3, then raises eng_done[1] -> single eng_start=2'b10 pulse; four data_out_valid pulses carrying 0xA0..0xA3, one per tx_done edge; core_busy falls after the 4th edge.
REQ-025 Header with SEL=5 (NUM_ENG=2), then a header with LEN=0 -> err=1 each time, state stays IDLE, core_busy=0; the next valid header clears err.
REQ-026 LEN=BUF_DEPTH=128 -> all 128 words buffered, 128 words transmitted, no counter wrap.
REQ-027 data_in_valid held high for 10 cycles during RECEIVE -> exactly one word written; tx_done edges during COMPUTE -> no output.
REQ-028 rstb asserted in TRANSMIT after 2 of 4 words -> all outputs 0 immediately; a fresh command then completes normally.
REQ-029 With CORE_DISPATCH_TIMEOUT_EN and TIMEOUT=16, eng_done never raised -> err=1 sixteen cycles after START, return to IDLE, zero data_out_valid pulses.
